// File: rtl/intersection_phase_ctrl_pkg.sv
// Shared types and constants for the two-approach intersection controller.
package intersection_phase_ctrl_pkg;

  // Controller phases; IDLE is the powered-down / disabled state.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_MAIN_GREEN  = 3'd1,
    ST_MAIN_YELLOW = 3'd2,
    ST_ALL_RED_1   = 3'd3,
    ST_SIDE_GREEN  = 3'd4,
    ST_SIDE_YELLOW = 3'd5,
    ST_ALL_RED_2   = 3'd6
  } phase_e;

  // Lamp bit positions within a 3-bit signal group.
  localparam int GREEN_IDX  = 0;
  localparam int YELLOW_IDX = 1;
  localparam int RED_IDX    = 2;

  localparam logic [2:0] LAMP_OFF    = 3'b000;
  localparam logic [2:0] LAMP_GREEN  = 3'b001 << GREEN_IDX;
  localparam logic [2:0] LAMP_YELLOW = 3'b001 << YELLOW_IDX;
  localparam logic [2:0] LAMP_RED    = 3'b001 << RED_IDX;

  // Lamp pair driven for one phase.
  typedef struct packed {
    logic [2:0] main;
    logic [2:0] side;
  } lamps_t;

  // Lamp decode: exactly one lamp per group outside IDLE, and at most one
  // group ever shows anything other than red.
  function automatic lamps_t lamps_of(input phase_e s);
    lamps_t l;
    l.main = LAMP_OFF;
    l.side = LAMP_OFF;
    case (s)
      ST_MAIN_GREEN:  begin l.main = LAMP_GREEN;  l.side = LAMP_RED;    end
      ST_MAIN_YELLOW: begin l.main = LAMP_YELLOW; l.side = LAMP_RED;    end
      ST_ALL_RED_1:   begin l.main = LAMP_RED;    l.side = LAMP_RED;    end
      ST_SIDE_GREEN:  begin l.main = LAMP_RED;    l.side = LAMP_GREEN;  end
      ST_SIDE_YELLOW: begin l.main = LAMP_RED;    l.side = LAMP_YELLOW; end
      ST_ALL_RED_2:   begin l.main = LAMP_RED;    l.side = LAMP_RED;    end
      default:        begin l.main = LAMP_OFF;    l.side = LAMP_OFF;    end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/intersection_phase_ctrl_phase_timer.sv
// Per-phase down-counter in sec_ticks. Loads a duration on phase entry,
// decrements on tick and flags expiry on the tick seen while at 1.
module intersection_phase_ctrl_phase_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  input  logic         hold,
  output logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt;

  // Counter: clear beats load beats tick; with hold set it parks at 1.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (tick && (cnt != '0) && !(hold && (cnt == W'(1))))
      cnt <= cnt - W'(1);
  end

  assign value  = cnt;
  assign expire = tick && (cnt == W'(1));

endmodule

// File: rtl/intersection_phase_ctrl.sv
// Main/side intersection scheduler: main rests in green, side road and
// pedestrians are served on demand after the main minimum green.
module intersection_phase_ctrl
  import intersection_phase_ctrl_pkg::*;
#(
  parameter int pMIN_GREEN  = 10,
  parameter int pSIDE_GREEN = 8,
  parameter int pYELLOW     = 3,
  parameter int pALL_RED    = 1,
  parameter int pCNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  sec_tick,
  input  logic                  side_req,
  input  logic                  ped_req,
  output logic [2:0]            main_light,
  output logic [2:0]            side_light,
  output logic                  walk,
  output logic [pCNT_WIDTH-1:0] phase_remain,
  output logic                  phase_change
);

  phase_e                state, state_nxt;
  logic                  ped_pending, walk_flag;
  logic                  tick, demand, entering, sg_entry, sg_exit;
  logic                  tmr_clr, tmr_load, tmr_expire;
  logic [pCNT_WIDTH-1:0] tmr_load_val, tmr_value;
  lamps_t                lamps;

  // Duration loaded when a phase is entered.
  function automatic logic [pCNT_WIDTH-1:0] dur_of(input phase_e s);
    case (s)
      ST_MAIN_GREEN:  return pCNT_WIDTH'(pMIN_GREEN);
      ST_MAIN_YELLOW: return pCNT_WIDTH'(pYELLOW);
      ST_ALL_RED_1:   return pCNT_WIDTH'(pALL_RED);
      ST_SIDE_GREEN:  return pCNT_WIDTH'(pSIDE_GREEN);
      ST_SIDE_YELLOW: return pCNT_WIDTH'(pYELLOW);
      ST_ALL_RED_2:   return pCNT_WIDTH'(pALL_RED);
      default:        return '0;
    endcase
  endfunction

  // Ticks only count while running; a raw ped_req is demand even before it
  // reaches the latch.
  assign tick   = en && sec_tick && (state != ST_IDLE);
  assign demand = side_req || ped_pending || ped_req;

  // Next-state logic; disable wins from any state.
  always_comb begin
    state_nxt = state;
    tmr_clr   = 1'b0;
    if (!en) begin
      state_nxt = ST_IDLE;
      tmr_clr   = 1'b1;
    end else begin
      case (state)
        ST_IDLE:        state_nxt = ST_ALL_RED_2;
        ST_ALL_RED_2:   if (tmr_expire)           state_nxt = ST_MAIN_GREEN;
        ST_MAIN_GREEN:  if (tmr_expire && demand) state_nxt = ST_MAIN_YELLOW;
        ST_MAIN_YELLOW: if (tmr_expire)           state_nxt = ST_ALL_RED_1;
        ST_ALL_RED_1:   if (tmr_expire)           state_nxt = ST_SIDE_GREEN;
        ST_SIDE_GREEN:  if (tmr_expire)           state_nxt = ST_SIDE_YELLOW;
        ST_SIDE_YELLOW: if (tmr_expire)           state_nxt = ST_ALL_RED_2;
        default:        state_nxt = ST_IDLE;
      endcase
    end
  end

  // Every transition into a running phase reloads the timer.
  assign entering     = en && (state_nxt != state) && (state_nxt != ST_IDLE);
  assign tmr_load     = entering;
  assign tmr_load_val = dur_of(state_nxt);
  assign sg_entry     = entering && (state_nxt == ST_SIDE_GREEN);
  assign sg_exit      = (state == ST_SIDE_GREEN) && (state_nxt != ST_SIDE_GREEN);

  intersection_phase_ctrl_phase_timer #(
    .W (pCNT_WIDTH)
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tick     (tick),
    .hold     (state == ST_MAIN_GREEN),
    .value    (tmr_value),
    .expire   (tmr_expire)
  );

  // State register plus a registered pulse marking each transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      phase_change <= 1'b0;
    end else begin
      state        <= state_nxt;
      phase_change <= (state_nxt != state);
    end
  end

  // Pedestrian latch: walk is decided once at side-green entry, so a late
  // press waits for the next side phase instead of raising walk mid-phase.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      ped_pending <= 1'b0;
      walk_flag   <= 1'b0;
    end else if (sg_entry) begin
      walk_flag   <= ped_pending || ped_req;
      ped_pending <= 1'b0;
    end else begin
      if (ped_req && (state != ST_IDLE))
        ped_pending <= 1'b1;
      if (sg_exit)
        walk_flag <= 1'b0;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    lamps        = lamps_of(state);
    main_light   = lamps.main;
    side_light   = lamps.side;
    walk         = walk_flag && (state == ST_SIDE_GREEN);
    phase_remain = tmr_value;
  end

endmodule

// File: tb/tb_intersection_phase_ctrl.sv
// Self-checking bench for intersection_phase_ctrl: directed scenarios then
// randomized traffic, all compared against a table-driven phase model.
module tb_intersection_phase_ctrl;

  localparam int MIN_G  = 10;
  localparam int SIDE_G = 8;
  localparam int YEL    = 3;
  localparam int AR     = 1;
  localparam int W      = 6;

  logic         clk = 1'b0;
  logic         rst_n, en, sec_tick, side_req, ped_req;
  logic [2:0]   main_light, side_light;
  logic         walk, phase_change;
  logic [W-1:0] phase_remain;

  always #5 clk = ~clk;

  intersection_phase_ctrl #(
    .pMIN_GREEN  (MIN_G),
    .pSIDE_GREEN (SIDE_G),
    .pYELLOW     (YEL),
    .pALL_RED    (AR),
    .pCNT_WIDTH  (W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sec_tick     (sec_tick),
    .side_req     (side_req),
    .ped_req      (ped_req),
    .main_light   (main_light),
    .side_light   (side_light),
    .walk         (walk),
    .phase_remain (phase_remain),
    .phase_change (phase_change)
  );

  int checks   = 0;
  int failures = 0;
  int pc_cnt   = 0;

  // Model: phase index into a ring -1=idle, 0=AR2 1=MG 2=MY 3=AR1 4=SG 5=SY.
  int         m_ph, m_rem;
  bit         m_pend, m_wflag, m_pc;
  int         dur   [6];
  logic [2:0] mlamp [6];
  logic [2:0] slamp [6];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [2:0] em, es;
    em = (m_ph < 0) ? 3'b000 : mlamp[m_ph];
    es = (m_ph < 0) ? 3'b000 : slamp[m_ph];
    chk({tag, "/main"},   32'(main_light),   32'(em));
    chk({tag, "/side"},   32'(side_light),   32'(es));
    chk({tag, "/walk"},   32'(walk),         32'(m_wflag && m_ph == 4));
    chk({tag, "/remain"}, 32'(phase_remain), m_rem);
    chk({tag, "/pchg"},   32'(phase_change), 32'(m_pc));
    chk({tag, "/safe"},   32'(main_light[2] || side_light[2] ||
                              (main_light == 3'b000 && side_light == 3'b000)), 32'd1);
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    bit np, demand;
    if (!rst_n) begin
      m_ph = -1; m_rem = 0; m_pend = 0; m_wflag = 0; m_pc = 0;
    end else if (!en) begin
      m_pc = (m_ph != -1);
      m_ph = -1; m_rem = 0; m_pend = 0; m_wflag = 0;
    end else if (m_ph == -1) begin
      m_ph = 0; m_rem = dur[0]; m_pc = 1;
    end else begin
      np     = m_pend | ped_req;
      demand = side_req | m_pend | ped_req;
      m_pc   = 0;
      if (sec_tick) begin
        if (m_rem > 1) m_rem--;
        else if (m_ph != 1 || demand) begin
          if (m_ph == 4) m_wflag = 0;
          m_ph  = (m_ph + 1) % 6;
          m_rem = dur[m_ph];
          m_pc  = 1;
          if (m_ph == 4) begin
            m_wflag = m_pend | ped_req;
            np      = 0;
          end
        end
      end
      m_pend = np;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_outputs("cyc");
    if (phase_change) pc_cnt++;
  endtask

  // n second-ticks, each followed by a quiet cycle.
  task automatic tick(input int n);
    repeat (n) begin
      sec_tick = 1'b1; cyc();
      sec_tick = 1'b0; cyc();
    end
  endtask

  task automatic ped_pulse();
    ped_req = 1'b1; cyc();
    ped_req = 1'b0;
  endtask

  initial begin
    dur[0] = AR;    mlamp[0] = 3'b100; slamp[0] = 3'b100;
    dur[1] = MIN_G; mlamp[1] = 3'b001; slamp[1] = 3'b100;
    dur[2] = YEL;   mlamp[2] = 3'b010; slamp[2] = 3'b100;
    dur[3] = AR;    mlamp[3] = 3'b100; slamp[3] = 3'b100;
    dur[4] = SIDE_G;mlamp[4] = 3'b100; slamp[4] = 3'b001;
    dur[5] = YEL;   mlamp[5] = 3'b100; slamp[5] = 3'b010;
    m_ph = -1; m_rem = 0; m_pend = 0; m_wflag = 0; m_pc = 0;

    rst_n = 1'b0; en = 1'b0; sec_tick = 1'b0; side_req = 1'b0; ped_req = 1'b0;
    cyc(); cyc();
    chk("rst_main", 32'(main_light), 32'd0);
    chk("rst_remain", 32'(phase_remain), 32'd0);

    // Startup through clearance into resting main green.
    rst_n = 1'b1; en = 1'b1;
    cyc();
    chk("start_ar2_main", 32'(main_light), 32'(3'b100));
    chk("start_ar2_remain", 32'(phase_remain), 32'd1);
    tick(1);
    chk("mg_entry_remain", 32'(phase_remain), 32'd10);
    tick(9);
    chk("mg_min_remain", 32'(phase_remain), 32'd1);
    tick(50);
    chk("mg_rest_main", 32'(main_light), 32'(3'b001));
    chk("mg_rest_remain", 32'(phase_remain), 32'd1);

    // Side service cycle; a late ped press in side green must not raise walk.
    pc_cnt = 0;
    side_req = 1'b1;
    tick(1);
    chk("my_entry", 32'(main_light), 32'(3'b010));
    tick(4);
    side_req = 1'b0;
    chk("sg_nowalk", 32'(walk), 32'd0);
    tick(2);
    ped_pulse();
    chk("sg_late_ped", 32'(walk), 32'd0);
    tick(6);
    tick(4);
    chk("cycle_pchg_count", 32'(pc_cnt), 32'd6);
    chk("back_mg_remain", 32'(phase_remain), 32'd10);

    // Pending ped serves the next side phase after min green.
    tick(9);
    chk("pend_mg_hold", 32'(main_light), 32'(3'b001));
    tick(1);
    chk("pend_exit", 32'(main_light), 32'(3'b010));
    tick(4);
    chk("pend_walk", 32'(walk), 32'd1);
    tick(8);
    chk("sy_walk_off", 32'(walk), 32'd0);
    tick(4);

    // side_req from 3rd tick of main green: exit on 10th tick.
    tick(2);
    side_req = 1'b1;
    tick(7);
    chk("sr3_hold", 32'(main_light), 32'(3'b001));
    tick(1);
    chk("sr3_exit", 32'(main_light), 32'(3'b010));
    side_req = 1'b0;
    tick(4);
    chk("sr3_nowalk", 32'(walk), 32'd0);
    tick(8);
    tick(4);

    // Single-cycle ped press in main green.
    ped_pulse();
    tick(10);
    chk("ped_exit", 32'(main_light), 32'(3'b010));
    tick(4);
    chk("ped_walk_first", 32'(walk), 32'd1);
    tick(7);
    chk("ped_walk_last", 32'(walk), 32'd1);
    tick(1);
    tick(4);
    tick(20);
    chk("ped_cleared", 32'(main_light), 32'(3'b001));

    // en dropped mid side green.
    side_req = 1'b1;
    tick(1);
    side_req = 1'b0;
    tick(4);
    ped_pulse();
    tick(3);
    en = 1'b0;
    cyc();
    chk("dis_main", 32'(main_light), 32'd0);
    chk("dis_remain", 32'(phase_remain), 32'd0);
    cyc(); cyc();
    en = 1'b1;
    cyc();
    chk("reen_ar2", 32'(side_light), 32'(3'b100));
    tick(1);
    chk("reen_mg", 32'(phase_remain), 32'd10);
    tick(12);
    chk("reen_no_pend", 32'(main_light), 32'(3'b001));

    // Reset coincident with a tick in main yellow.
    side_req = 1'b1;
    tick(1);
    side_req = 1'b0;
    tick(1);
    rst_n = 1'b0; sec_tick = 1'b1;
    #1;
    chk("rst_pre_edge", 32'(main_light), 32'(3'b010));
    cyc();
    sec_tick = 1'b0;
    chk("rst_post_main", 32'(main_light), 32'd0);
    chk("rst_post_side", 32'(side_light), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Randomized traffic.
    repeat (1500) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      en       = ($urandom_range(0, 99) != 0);
      sec_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) side_req = ~side_req;
      ped_req  = ($urandom_range(0, 29) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
